serial_word_assembler: RTL

//   Downstream companion of the left-shift PISO register: consumes its MSB-first serial stream.

---
 rtl/serial_word_assembler_if.sv | 23 ++
 rtl/serial_word_assembler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_word_assembler_if.sv
// Word-side handshake of serial_word_assembler: show-ahead head word with valid/ready.
interface serial_word_assembler_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_ready;
    logic             parity_err;

    modport master (
        output word_data,
        output word_valid,
        output parity_err,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        input  parity_err,
        output word_ready
    );
endinterface

// File: rtl/serial_word_assembler.sv
// Rebuilds sync-aligned MSB-first serial words into a show-ahead FIFO with sticky overflow.
// Optional trailing even-parity bit per word: define PARITY_CHECK_EN.
module serial_word_assembler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     serial_in,
    input  logic                     sync,
    input  logic                     clr_ovf,
    serial_word_assembler_if.master  word_if,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StHunt, StData, StParity} state_e;

    state_e           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;

    logic             push_word;
    logic [WIDTH-1:0] push_data;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    // Low WIDTH bits of the concatenation: oldest bit falls off the top.
    assign shreg_next = WIDTH'({shreg, serial_in});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StHunt;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (en) begin
            shreg <= shreg_next;
            if (sync) begin
                state   <= StData;
                bit_cnt <= CW'(1);
            end else begin
                case (state)
                    StHunt: ;
                    StData: begin
                        if (bit_cnt == LastBit) begin
                            bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
                            state   <= StParity;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    StParity: state <= StData;
                    default:  state <= StHunt;
                endcase
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic push_perr;
    logic mem_perr [DEPTH];

    always_comb begin
        push_word = 1'b0;
        push_data = shreg;
        push_perr = 1'b0;
        if (en && !sync && state == StParity) begin
            push_word = 1'b1;
            push_perr = ^{shreg, serial_in};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_perr[wr_ptr] <= push_perr;
        end
    end

    assign word_if.parity_err = word_if.word_valid ? mem_perr[rd_ptr] : 1'b0;
`else
    always_comb begin
        push_word = 1'b0;
        push_data = shreg_next;
        if (en && !sync && state == StData && bit_cnt == LastBit) begin
            push_word = 1'b1;
        end
    end

    assign word_if.parity_err = 1'b0;
`endif

    assign full    = (fill == FullLevel);
    assign do_pop  = word_if.word_valid && word_if.word_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the word.
    assign do_push = push_word && (!full || do_pop);
    assign drop    = push_word && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign level              = fill;
    assign word_if.word_valid = (fill != '0);
    assign word_if.word_data  = word_if.word_valid ? mem[rd_ptr] : '0;
endmodule
